// File: rtl/instruction_memory_sync.sv
// Clocked instruction memory with registered 1-cycle fetch, stall hold and a streaming program-load port.
// Optional feature: define MISALIGN_CHECK_EN to add the rd_err output for fetches with rd_addr[1:0] != 0.
module instruction_memory_sync #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     freeze,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
`ifdef MISALIGN_CHECK_EN
    output logic                     rd_err,
`endif
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_last,
    output logic                     load_busy,
    output logic                     load_done,
    output logic                     load_ovf,
    output logic [$clog2(DEPTH):0]   word_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RUN, LOAD} state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DATA_W-1:0]       mem_d [DEPTH];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]       rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    load_done_q, load_done_d;
    logic                    load_ovf_q, load_ovf_d;
`ifdef MISALIGN_CHECK_EN
    logic                    rd_err_q, rd_err_d;
`endif

    logic [ADDR_W-1:0]       word_idx;
    logic [AW-1:0]           rd_idx;
    logic                    idx_in_range;

    // DEPTH is a power of two, so an index is in range exactly when its bits above AW are zero
    assign word_idx     = rd_addr >> 2;
    assign rd_idx       = word_idx[AW-1:0];
    assign idx_in_range = (word_idx >> AW) == '0;

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        load_done_d = 1'b0;
        load_ovf_d  = load_ovf_q;
`ifdef MISALIGN_CHECK_EN
        rd_err_d    = rd_err_q;
`endif
        case (state_q)
            RUN: begin
                if (load_start) begin
                    state_d    = LOAD;
                    wr_ptr_d   = '0;
                    load_ovf_d = 1'b0;
                    rd_valid_d = 1'b0;
`ifdef MISALIGN_CHECK_EN
                    rd_err_d   = 1'b0;
`endif
                end else if (!freeze) begin
                    rd_valid_d = rd_en;
`ifdef MISALIGN_CHECK_EN
                    rd_err_d   = 1'b0;
`endif
                    if (rd_en) begin
                        rd_data_d = idx_in_range ? mem_q[rd_idx] : FILL_WORD;
`ifdef MISALIGN_CHECK_EN
                        if (rd_addr[1:0] != 2'b00) begin
                            rd_data_d = FILL_WORD;
                            rd_err_d  = 1'b1;
                        end
`endif
                    end
                end
            end
            LOAD: begin
                rd_valid_d = 1'b0;
`ifdef MISALIGN_CHECK_EN
                rd_err_d   = 1'b0;
`endif
                // Pointer top bit set means DEPTH words are already in; further beats only flag overflow
                if (load_valid) begin
                    if (!wr_ptr_q[AW]) begin
                        mem_d[wr_ptr_q[AW-1:0]] = load_data;
                        wr_ptr_d                = wr_ptr_q + 1'b1;
                    end else begin
                        load_ovf_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_data_q   <= FILL_WORD;
            rd_valid_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_ovf_q  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            rd_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            load_done_q <= load_done_d;
            load_ovf_q  <= load_ovf_d;
`ifdef MISALIGN_CHECK_EN
            rd_err_q    <= rd_err_d;
`endif
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign load_busy  = (state_q == LOAD);
    assign load_done  = load_done_q;
    assign load_ovf   = load_ovf_q;
    assign word_count = wr_ptr_q;
`ifdef MISALIGN_CHECK_EN
    assign rd_err     = rd_err_q;
`endif

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed self-checking bench for instruction_memory_sync (default parameters).
module tb_instruction_memory_sync;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] FILL   = 32'h0000_0000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    rd_en = 1'b0;
    logic [ADDR_W-1:0]       rd_addr = '0;
    logic                    freeze = 1'b0;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
`ifdef MISALIGN_CHECK_EN
    logic                    rd_err;
`endif
    logic                    load_start = 1'b0;
    logic                    load_valid = 1'b0;
    logic [DATA_W-1:0]       load_data = '0;
    logic                    load_last = 1'b0;
    logic                    load_busy;
    logic                    load_done;
    logic                    load_ovf;
    logic [$clog2(DEPTH):0]  word_count;

    int compared   = 0;
    int mismatched = 0;

    instruction_memory_sync #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FILL_WORD(FILL)
    ) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .freeze(freeze),
        .rd_data(rd_data), .rd_valid(rd_valid),
`ifdef MISALIGN_CHECK_EN
        .rd_err(rd_err),
`endif
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_busy(load_busy), .load_done(load_done),
        .load_ovf(load_ovf), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] addr);
        rd_en   = en;
        rd_addr = addr;
        tick();
    endtask

    task automatic loadBeat(input logic [31:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic startLoad();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) tick();
        checkOutput("reset_rd_data", rd_data, FILL);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_busy", 32'(load_busy), 32'd0);
        checkOutput("reset_done", 32'(load_done), 32'd0);
        checkOutput("reset_ovf", 32'(load_ovf), 32'd0);
        checkOutput("reset_wc", 32'(word_count), 32'd0);
        rst = 1'b1;
        tick();

        // Fetch from a freshly reset memory
        applyStimulus(1'b1, 32'h0);
        checkOutput("t1_valid", 32'(rd_valid), 32'd1);
        checkOutput("t1_data", rd_data, 32'h0);
        rd_en = 1'b0;

        // Three-beat load with a stray load_start mid-load
        startLoad();
        checkOutput("t2_busy", 32'(load_busy), 32'd1);
        checkOutput("t2_valid_forced", 32'(rd_valid), 32'd0);
        loadBeat(32'hE3A0_0015, 1'b0);
        load_start = 1'b1;
        loadBeat(32'hE3A0_1A01, 1'b0);
        load_start = 1'b0;
        checkOutput("t2_busy_mid", 32'(load_busy), 32'd1);
        loadBeat(32'hEAFF_FFFF, 1'b1);
        checkOutput("t2_done", 32'(load_done), 32'd1);
        checkOutput("t2_busy_end", 32'(load_busy), 32'd0);
        checkOutput("t2_wc", 32'(word_count), 32'd3);
        applyStimulus(1'b1, 32'h0);
        checkOutput("t2_done_pulse", 32'(load_done), 32'd0);
        checkOutput("t2_w0", rd_data, 32'hE3A0_0015);
        applyStimulus(1'b1, 32'h4);
        checkOutput("t2_w1", rd_data, 32'hE3A0_1A01);
        applyStimulus(1'b1, 32'h8);
        checkOutput("t2_w2", rd_data, 32'hEAFF_FFFF);
        checkOutput("t2_w2_valid", 32'(rd_valid), 32'd1);

        // Freeze holds the read outputs while the address moves
        applyStimulus(1'b1, 32'h4);
        checkOutput("t3_pre", rd_data, 32'hE3A0_1A01);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h8);
            checkOutput("t3_hold_data", rd_data, 32'hE3A0_1A01);
            checkOutput("t3_hold_valid", 32'(rd_valid), 32'd1);
        end
        freeze = 1'b0;
        applyStimulus(1'b1, 32'h8);
        checkOutput("t3_release", rd_data, 32'hEAFF_FFFF);
        applyStimulus(1'b0, 32'h8);
        checkOutput("t3_idle_valid", 32'(rd_valid), 32'd0);
        checkOutput("t3_idle_data", rd_data, 32'hEAFF_FFFF);

        // Overflow: 66 beats into a 64-word memory
        startLoad();
        for (int i = 0; i < 66; i++) loadBeat(32'h1000_0000 + 32'(i), (i == 65));
        checkOutput("t4_done", 32'(load_done), 32'd1);
        checkOutput("t4_ovf", 32'(load_ovf), 32'd1);
        checkOutput("t4_wc", 32'(word_count), 32'd64);
        applyStimulus(1'b1, 32'h100);
        checkOutput("t4_oor_data", rd_data, FILL);
        checkOutput("t4_oor_valid", 32'(rd_valid), 32'd1);
        applyStimulus(1'b1, 32'hFC);
        checkOutput("t4_last_word", rd_data, 32'h1000_003F);
        rd_en = 1'b0;
        checkOutput("t4_ovf_sticky", 32'(load_ovf), 32'd1);

        // One-word load; other words keep their contents
        startLoad();
        checkOutput("t4b_ovf_clear", 32'(load_ovf), 32'd0);
        checkOutput("t4b_wc_clear", 32'(word_count), 32'd0);
        load_last = 1'b1;
        tick();
        load_last = 1'b0;
        checkOutput("t4b_last_novalid", 32'(load_busy), 32'd1);
        loadBeat(32'hAAAA_5555, 1'b1);
        checkOutput("t4b_wc", 32'(word_count), 32'd1);
        applyStimulus(1'b1, 32'h4);
        checkOutput("t4b_kept", rd_data, 32'h1000_0001);
        applyStimulus(1'b1, 32'h0);
        checkOutput("t4b_new", rd_data, 32'hAAAA_5555);
        rd_en = 1'b0;

        // Reset in the middle of a load
        startLoad();
        loadBeat(32'h0000_0011, 1'b0);
        loadBeat(32'h0000_0022, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("t5_busy_async", 32'(load_busy), 32'd0);
        checkOutput("t5_wc", 32'(word_count), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(1'b1, 32'h0);
        checkOutput("t5_w0", rd_data, 32'h0);
        applyStimulus(1'b1, 32'h4);
        checkOutput("t5_w1", rd_data, 32'h0);
        checkOutput("t5_valid", 32'(rd_valid), 32'd1);

        // load_start and rd_en together: load wins
        rd_addr    = 32'h4;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checkOutput("t6_valid", 32'(rd_valid), 32'd0);
        checkOutput("t6_busy", 32'(load_busy), 32'd1);
        applyStimulus(1'b1, 32'h0);
        checkOutput("t6_drop", 32'(rd_valid), 32'd0);
        rd_en = 1'b0;
        loadBeat(32'h1234_5678, 1'b1);
        checkOutput("t6_wc", 32'(word_count), 32'd1);

        // Load starts and completes with freeze held; fetch accepted on the done cycle
        freeze = 1'b1;
        startLoad();
        checkOutput("t6_frz_busy", 32'(load_busy), 32'd1);
        loadBeat(32'h9ABC_DEF0, 1'b1);
        checkOutput("t6_frz_done", 32'(load_done), 32'd1);
        freeze = 1'b0;
        applyStimulus(1'b1, 32'h0);
        checkOutput("t6_done_fetch_valid", 32'(rd_valid), 32'd1);
        checkOutput("t6_done_fetch_data", rd_data, 32'h9ABC_DEF0);

`ifdef MISALIGN_CHECK_EN
        applyStimulus(1'b1, 32'h6);
        checkOutput("t6_mis_err", 32'(rd_err), 32'd1);
        checkOutput("t6_mis_data", rd_data, FILL);
        checkOutput("t6_mis_valid", 32'(rd_valid), 32'd1);
        applyStimulus(1'b1, 32'h0);
        checkOutput("t6_aligned_err", 32'(rd_err), 32'd0);
`endif
        rd_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
